// File: rtl/mem_arb_pkg.sv
`default_nettype none
// =====================================================================
// mem_arb_pkg : shared types and defaults for the CPU/DMA memory arbiter
// Revision    : 1.0
// =====================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } arb_owner_t;

    localparam int unsigned c_default_timeout = 16;

endpackage
`default_nettype wire

// File: rtl/arb_watchdog.sv
`default_nettype none
// =====================================================================
// arb_watchdog : counts stalled access cycles, flags expiry (TIMEOUT=0 off)
// Revision     : 1.0
// =====================================================================
module arb_watchdog
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = c_default_timeout
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic ready,
    output logic expired
);

    generate
        if (TIMEOUT == 0) begin : g_disabled
            logic w_unused;
            assign w_unused = &{1'b0, clk, reset, clear, enable, ready};
            assign expired  = 1'b0;
        end else begin : g_enabled
            localparam int unsigned c_cnt_w = $clog2(TIMEOUT + 1);

            logic [c_cnt_w-1:0] r_count;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_count <= '0;
                end else if (clear) begin
                    r_count <= '0;
                end else if (enable && !ready && (r_count != c_cnt_w'(TIMEOUT))) begin
                    r_count <= r_count + 1'b1;
                end
            end

            // Fires on the stalled cycle that makes the count reach TIMEOUT;
            // a ready in that same cycle wins.
            assign expired = enable && !ready && (r_count == c_cnt_w'(TIMEOUT - 1));
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// =====================================================================
// mem_arbiter : CPU/DMA arbiter for one single-ported memory with watchdog.
//               Define ARB_ROUND_ROBIN_EN for round-robin tie breaking.
// Revision    : 1.0
// =====================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = c_default_timeout
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_done,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    arb_owner_t        r_owner;
    arb_owner_t        w_grant_owner;
    logic              w_grant;
    logic              w_finish;
    logic              w_expired;
    logic              w_pick_dma;
    logic [DATA_W-1:0] w_resp_data;

    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_cpu_done;
    logic              r_cpu_err;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic              r_dma_done;
    logic              r_dma_err;
    logic [DATA_W-1:0] r_dma_rdata;

`ifdef ARB_ROUND_ROBIN_EN
    arb_owner_t r_last_owner;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_last_owner <= OWN_DMA;
        end else if (w_grant) begin
            r_last_owner <= w_grant_owner;
        end
    end

    assign w_pick_dma = (r_last_owner == OWN_CPU);
`else
    assign w_pick_dma = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_grant       = 1'b0;
        w_grant_owner = OWN_CPU;
        w_finish      = 1'b0;
        case (r_state)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    w_grant     = 1'b1;
                    w_state_nxt = BUSY;
                    if (cpu_req && dma_req) begin
                        w_grant_owner = w_pick_dma ? OWN_DMA : OWN_CPU;
                    end else begin
                        w_grant_owner = cpu_req ? OWN_CPU : OWN_DMA;
                    end
                end
            end
            BUSY: begin
                if (mem_ready || w_expired) begin
                    w_finish    = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_grant),
        .enable  (r_state == BUSY),
        .ready   (mem_ready),
        .expired (w_expired)
    );

    // Writes and timeouts both return zero data.
    assign w_resp_data = (w_expired || r_mem_we) ? '0 : mem_rdata;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_owner     <= OWN_CPU;
            r_cpu_done  <= 1'b0;
            r_cpu_err   <= 1'b0;
            r_cpu_rdata <= '0;
            r_dma_done  <= 1'b0;
            r_dma_err   <= 1'b0;
            r_dma_rdata <= '0;
        end else begin
            r_cpu_done <= 1'b0;
            r_dma_done <= 1'b0;
            if (w_grant) begin
                r_mem_req <= 1'b1;
                r_owner   <= w_grant_owner;
                if (w_grant_owner == OWN_CPU) begin
                    r_mem_we    <= cpu_we;
                    r_mem_addr  <= cpu_addr;
                    r_mem_wdata <= cpu_wdata;
                end else begin
                    r_mem_we    <= dma_we;
                    r_mem_addr  <= dma_addr;
                    r_mem_wdata <= dma_wdata;
                end
            end
            if (w_finish) begin
                r_mem_req <= 1'b0;
                if (r_owner == OWN_CPU) begin
                    r_cpu_done  <= 1'b1;
                    r_cpu_rdata <= w_resp_data;
                    r_cpu_err   <= w_expired;
                end else begin
                    r_dma_done  <= 1'b1;
                    r_dma_rdata <= w_resp_data;
                    r_dma_err   <= w_expired;
                end
            end
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign cpu_done  = r_cpu_done;
    assign cpu_rdata = r_cpu_rdata;
    assign cpu_err   = r_cpu_err;
    assign dma_done  = r_dma_done;
    assign dma_rdata = r_dma_rdata;
    assign dma_err   = r_dma_err;
    assign cpu_stall = cpu_req & ~r_cpu_done;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// =====================================================================
// tb_mem_arbiter : directed and randomized checks of mem_arbiter against
//                  a transaction-level timing model (TIMEOUT = 4)
// Revision       : 1.0
// =====================================================================
module tb_mem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we, mem_ready;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;
    logic        cpu_done, cpu_err, cpu_stall, dma_done, dma_err, mem_req, mem_we;
    logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;

    mem_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_done  (cpu_done),
        .cpu_rdata (cpu_rdata),
        .cpu_err   (cpu_err),
        .cpu_stall (cpu_stall),
        .dma_req   (dma_req),
        .dma_we    (dma_we),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_done  (dma_done),
        .dma_rdata (dma_rdata),
        .dma_err   (dma_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model: each transfer = grant cycle g, BUSY cycles g+1..g+L, done at g+L+1.
    int          t;
    logic        rst_v;
    logic        rand_mode;
    logic        rq[2], rwe[2], granted[2], keep[2], done_prev[2];
    logic [31:0] raddr[2], rwd[2];
    int          gap[2];
    int          free_at, win_lo, win_hi, resp_c, rdy_c, own, last_owner;
    logic        lat_we, resp_err;
    logic [31:0] lat_addr, lat_wd, resp_rd;
    logic [31:0] m_rd[2];
    logic        m_err[2];
    int          force_wait;
    logic        force_md_en;
    logic [31:0] force_md;
    int          done_order[$];

    task automatic new_fields(input int r);
        rwe[r]   = 1'($urandom % 2);
        raddr[r] = $urandom;
        rwd[r]   = $urandom;
    endtask

    task automatic set_req(input int r, input logic we, input logic [31:0] a, input logic [31:0] d);
        rq[r] = 1'b1; rwe[r] = we; raddr[r] = a; rwd[r] = d;
    endtask

    task automatic model_reset();
        free_at = t + 1; win_lo = 1; win_hi = 0; resp_c = -1; rdy_c = -1; last_owner = 1;
        for (int r = 0; r < 2; r++) begin
            m_rd[r] = 32'h0; m_err[r] = 1'b0; granted[r] = 1'b0;
        end
    endtask

    task automatic update_req(input int r);
        if (done_prev[r]) begin
            granted[r] = 1'b0;
            if (rand_mode) begin
                if ($urandom_range(0, 1) == 1) begin
                    rq[r] = 1'b1; new_fields(r);
                end else begin
                    rq[r] = 1'b0; gap[r] = $urandom_range(0, 3);
                end
            end else if (!keep[r]) begin
                rq[r] = 1'b0;
            end
        end else if (rand_mode) begin
            if (!rq[r] && !granted[r]) begin
                if (gap[r] == 0) begin
                    rq[r] = 1'b1; new_fields(r);
                end else begin
                    gap[r]--;
                end
            end else if (rq[r] && $urandom_range(0, 9) == 0) begin
                rq[r] = 1'b0; gap[r] = $urandom_range(0, 3);
            end
        end
    endtask

    task automatic step();
        logic in_win;
        logic exp_done[2];
        int   w, len;
        @(posedge clk);
        #1;
        update_req(0);
        update_req(1);
        in_win    = (t >= win_lo) && (t <= win_hi);
        mem_rdata = $urandom;
        if (!rst_v)      mem_ready = 1'b0;
        else if (in_win) mem_ready = (t == rdy_c);
        else             mem_ready = ($urandom_range(0, 3) == 0);
        if (rst_v && t == rdy_c) begin
            if (force_md_en) mem_rdata = force_md;
            resp_rd = lat_we ? 32'h0 : mem_rdata;
        end
        exp_done[0] = (t == resp_c) && (own == 0);
        exp_done[1] = (t == resp_c) && (own == 1);
        if (t == resp_c) begin
            m_rd[own]  = resp_rd;
            m_err[own] = resp_err;
        end
        if (rst_v && t >= free_at && (rq[0] || rq[1])) begin
            if (rq[0] && rq[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
                own = (last_owner == 0) ? 1 : 0;
`else
                own = 0;
`endif
            end else begin
                own = rq[0] ? 0 : 1;
            end
            last_owner   = own;
            granted[own] = 1'b1;
            lat_we   = rwe[own];
            lat_addr = raddr[own];
            lat_wd   = rwd[own];
            w        = (force_wait >= 0) ? force_wait : $urandom_range(0, 5);
            resp_err = (w >= TO);
            len      = resp_err ? TO : w + 1;
            resp_rd  = 32'h0;
            win_lo   = t + 1;
            win_hi   = t + len;
            resp_c   = t + len + 1;
            free_at  = t + len + 2;
            rdy_c    = resp_err ? -1 : t + 1 + w;
        end
        reset     = rst_v;
        cpu_req   = rq[0]; cpu_we = rwe[0]; cpu_addr = raddr[0]; cpu_wdata = rwd[0];
        dma_req   = rq[1]; dma_we = rwe[1]; dma_addr = raddr[1]; dma_wdata = rwd[1];
        #1;
        check_eq("mem_req", mem_req, in_win);
        if (in_win) begin
            check_eq("mem_we", mem_we, lat_we);
            check_eq("mem_addr", mem_addr, lat_addr);
            check_eq("mem_wdata", mem_wdata, lat_wd);
        end
        check_eq("cpu_done", cpu_done, exp_done[0]);
        check_eq("dma_done", dma_done, exp_done[1]);
        check_eq("cpu_rdata", cpu_rdata, m_rd[0]);
        check_eq("cpu_err", cpu_err, m_err[0]);
        check_eq("dma_rdata", dma_rdata, m_rd[1]);
        check_eq("dma_err", dma_err, m_err[1]);
        check_eq("cpu_stall", cpu_stall, rq[0] & ~exp_done[0]);
        if (cpu_done) done_order.push_back(0);
        if (dma_done) done_order.push_back(1);
        done_prev = exp_done;
        if (!rst_v) model_reset();
        t++;
    endtask

    task automatic pulse_reset();
        rst_v = 1'b0;
        step();
        rst_v = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL sim_timeout: observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        int          n_req, n_done;
        logic [31:0] cap_rd;
        logic        cap_err;

        t = 0; rst_v = 1'b0; rand_mode = 1'b0;
        force_wait = -1; force_md_en = 1'b0; force_md = 32'h0;
        own = 0; lat_we = 1'b0; lat_addr = 32'h0; lat_wd = 32'h0;
        resp_rd = 32'h0; resp_err = 1'b0;
        for (int r = 0; r < 2; r++) begin
            rq[r] = 1'b0; rwe[r] = 1'b0; raddr[r] = 32'h0; rwd[r] = 32'h0;
            gap[r] = 0; keep[r] = 1'b0; done_prev[r] = 1'b0;
        end
        model_reset();
        free_at = 0;
        reset = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'h0; dma_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_mem_we", mem_we, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_wdata", mem_wdata, 0);
        check_eq("rst_cpu_done", cpu_done, 0);
        check_eq("rst_dma_done", dma_done, 0);
        check_eq("rst_cpu_rdata", cpu_rdata, 0);
        check_eq("rst_dma_rdata", dma_rdata, 0);
        check_eq("rst_cpu_err", cpu_err, 0);
        check_eq("rst_dma_err", dma_err, 0);
        reset = 1'b1; rst_v = 1'b1;

        // CPU read, zero wait
        set_req(0, 1'b0, 32'h100, 32'h0);
        force_wait = 0; force_md_en = 1'b1; force_md = 32'hDEADBEEF;
        repeat (3) step();
        check_eq("a_done", cpu_done, 1);
        check_eq("a_rdata", cpu_rdata, 32'hDEADBEEF);
        check_eq("a_err", cpu_err, 0);
        repeat (3) step();

        // Simultaneous requests after reset
        pulse_reset();
        force_md_en = 1'b0;
        set_req(0, 1'b0, 32'h10, 32'h0);
        set_req(1, 1'b0, 32'h20, 32'h0);
        keep[0] = 1'b1;
        done_order.delete();
        repeat (7) step();
        check_eq("b_count", done_order.size(), 2);
        if (done_order.size() >= 2) begin
            check_eq("b_first", done_order[0], 0);
`ifdef ARB_ROUND_ROBIN_EN
            check_eq("b_second", done_order[1], 1);
`else
            check_eq("b_second", done_order[1], 0);
`endif
        end
        keep[0] = 1'b0;
        repeat (12) step();

        // DMA write with 3 wait cycles
        set_req(1, 1'b1, 32'h40, 32'h12345678);
        force_wait = 3;
        n_req = 0; n_done = 0;
        repeat (8) begin
            step();
            if (mem_req && mem_we && mem_addr == 32'h40 && mem_wdata == 32'h12345678) n_req++;
            if (dma_done) n_done++;
        end
        check_eq("c_stable", n_req, 4);
        check_eq("c_done", n_done, 1);

        // Timeout: mem_ready never arrives
        set_req(0, 1'b0, 32'h200, 32'h0);
        force_wait = 9;
        n_req = 0; n_done = 0; cap_rd = 32'hFFFFFFFF; cap_err = 1'b0;
        repeat (8) begin
            step();
            if (mem_req) n_req++;
            if (cpu_done) begin n_done++; cap_rd = cpu_rdata; cap_err = cpu_err; end
        end
        check_eq("d_req_cycles", n_req, 4);
        check_eq("d_done", n_done, 1);
        check_eq("d_err", cap_err, 1);
        check_eq("d_rdata", cap_rd, 0);

        // Ready on the last allowed wait cycle
        set_req(0, 1'b0, 32'h300, 32'h0);
        force_wait = 3; force_md_en = 1'b1; force_md = 32'hCAFEF00D;
        n_req = 0; n_done = 0; cap_rd = 32'h0; cap_err = 1'b1;
        repeat (8) begin
            step();
            if (mem_req) n_req++;
            if (cpu_done) begin n_done++; cap_rd = cpu_rdata; cap_err = cpu_err; end
        end
        check_eq("e_req_cycles", n_req, 4);
        check_eq("e_done", n_done, 1);
        check_eq("e_err", cap_err, 0);
        check_eq("e_rdata", cap_rd, 32'hCAFEF00D);

        // Reset in the middle of BUSY
        set_req(0, 1'b0, 32'h400, 32'h0);
        force_wait = 9; force_md_en = 1'b0;
        n_done = 0;
        repeat (3) begin
            step();
            if (cpu_done) n_done++;
        end
        check_eq("f_busy", mem_req, 1);
        rst_v = 1'b0; rq[0] = 1'b0;
        step();
        if (cpu_done) n_done++;
        rst_v = 1'b1;
        step();
        check_eq("f_req_dropped", mem_req, 0);
        check_eq("f_addr_cleared", mem_addr, 0);
        repeat (6) begin
            step();
            if (cpu_done) n_done++;
        end
        check_eq("f_no_done", n_done, 0);
        set_req(0, 1'b0, 32'h500, 32'h0);
        force_wait = 0; force_md_en = 1'b1; force_md = 32'h0BADF00D;
        n_done = 0; cap_rd = 32'h0;
        repeat (4) begin
            step();
            if (cpu_done) begin n_done++; cap_rd = cpu_rdata; end
        end
        check_eq("f_after_done", n_done, 1);
        check_eq("f_after_rdata", cap_rd, 32'h0BADF00D);

        // Randomized traffic with occasional resets
        rand_mode = 1'b1; force_wait = -1; force_md_en = 1'b0;
        repeat (3000) begin
            rst_v = ($urandom_range(0, 399) != 0);
            step();
        end
        rst_v = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
